// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
// uart_rx_fifo: majority-voted UART receiver with latched per-character
// framing (5..DATA_WIDTH bits, optional parity, 1 or 2 stop bits) feeding
// a FIFO_DEPTH-entry receive FIFO presented as an AXI-stream head.
// Ports: clk, rst_n, rxd, prescale, data_bits, parity_mode, two_stop,
//   m_axis_tdata/tvalid/tready, fifo_count, busy,
//   frame_error, parity_error, overrun_error, break_det (1-cycle pulses).
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rxd,
    input  logic [15:0]                 prescale,
    input  logic [3:0]                  data_bits,
    input  logic [1:0]                  parity_mode,
    input  logic                        two_stop,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        frame_error,
    output logic                        parity_error,
    output logic                        overrun_error,
    output logic                        break_det
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_IDLE
    } state_t;

    // Input conditioning
    logic [1:0] sync;
    logic [2:0] hist;
    logic       maj;
    logic       samp_q;
    logic [2:0] arm_cnt;
    logic       armed;

    assign maj = (hist[0] & hist[1]) | (hist[0] & hist[2]) |
                 (hist[1] & hist[2]);

    // The first 5 post-reset cycles only flush preset ones out of the
    // synchronizer and history; arming then needs 3 real samples of 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            hist    <= 3'b111;
            samp_q  <= 1'b1;
            arm_cnt <= 3'd0;
            armed   <= 1'b0;
        end else begin
            sync   <= {sync[0], rxd};
            hist   <= {hist[1:0], sync[1]};
            samp_q <= maj;
            if (!armed) begin
                if (arm_cnt < 3'd5) arm_cnt <= arm_cnt + 3'd1;
                else if (!maj) arm_cnt <= 3'd5;
                else if (arm_cnt == 3'd7) armed <= 1'b1;
                else arm_cnt <= arm_cnt + 3'd1;
            end
        end
    end

    // Effective configuration seen at start detection
    logic [15:0] ps_eff;
    logic [3:0]  nb_eff;

    always_comb begin
        ps_eff = (prescale == 16'd0) ? 16'd1 : prescale;
        nb_eff = data_bits;
        if (data_bits < 4'd5) nb_eff = 4'd5;
        else if (data_bits > MAX_BITS) nb_eff = MAX_BITS;
    end

    // Receiver FSM
    state_t                state;
    logic [18:0]           timer;
    logic [15:0]           ps_l;
    logic [3:0]            nb_l;
    logic                  par_en_l;
    logic                  par_odd_l;
    logic                  two_stop_l;
    logic [3:0]            bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  par_pend;
    logic                  stop1_bit;

    logic [18:0] half_time;
    logic [18:0] bit_time;
    logic        expired;
    logic        final_stop;
    logic        stop_ok;
    logic        all_zero;
    logic        push;

    assign half_time  = {1'b0, ps_eff, 2'b00} - 19'd1;
    assign bit_time   = {ps_l, 3'b000} - 19'd1;
    assign expired    = (timer == 19'd0);
    assign final_stop = expired &&
                        ((state == STOP1 && !two_stop_l) ||
                         state == STOP2);
    assign stop_ok    = maj && (state != STOP2 || stop1_bit);
    assign all_zero   = (shreg == '0) && !(par_en_l && par_bit);
    assign push       = final_stop && stop_ok && !par_pend;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= 19'd0;
            ps_l         <= 16'd1;
            nb_l         <= 4'd5;
            par_en_l     <= 1'b0;
            par_odd_l    <= 1'b0;
            two_stop_l   <= 1'b0;
            bit_idx      <= 4'd0;
            shreg        <= '0;
            par_bit      <= 1'b0;
            par_pend     <= 1'b0;
            stop1_bit    <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            break_det    <= 1'b0;
        end else begin
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
            break_det    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (armed && samp_q && !maj) begin
                        state      <= START;
                        timer      <= half_time;
                        ps_l       <= ps_eff;
                        nb_l       <= nb_eff;
                        par_en_l   <= ^parity_mode;
                        par_odd_l  <= parity_mode[1];
                        two_stop_l <= two_stop;
                        bit_idx    <= 4'd0;
                        shreg      <= '0;
                        par_bit    <= 1'b0;
                        par_pend   <= 1'b0;
                    end
                end
                START: begin
                    if (!expired) timer <= timer - 19'd1;
                    else if (!maj) begin
                        state <= DATA;
                        timer <= bit_time;
                    end else state <= IDLE;
                end
                DATA: begin
                    if (!expired) timer <= timer - 19'd1;
                    else begin
                        for (int i = 0; i < DATA_WIDTH; i++)
                            if (bit_idx == 4'(i)) shreg[i] <= maj;
                        timer <= bit_time;
                        if (bit_idx == nb_l - 4'd1)
                            state <= par_en_l ? PARITY : STOP1;
                        else bit_idx <= bit_idx + 4'd1;
                    end
                end
                PARITY: begin
                    if (!expired) timer <= timer - 19'd1;
                    else begin
                        par_bit  <= maj;
                        par_pend <= (^shreg) ^ maj ^ par_odd_l;
                        timer    <= bit_time;
                        state    <= STOP1;
                    end
                end
                STOP1: begin
                    if (!expired) timer <= timer - 19'd1;
                    else begin
                        stop1_bit <= maj;
                        timer     <= bit_time;
                        if (two_stop_l) state <= STOP2;
                    end
                end
                STOP2: begin
                    if (!expired) timer <= timer - 19'd1;
                end
                WAIT_IDLE: begin
                    if (maj) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Character verdict at the last stop sample
            if (final_stop) begin
                if (stop_ok) begin
                    parity_error <= par_pend;
                    state        <= IDLE;
                end else begin
                    if (all_zero) break_det <= 1'b1;
                    else frame_error <= 1'b1;
                    state <= WAIT_IDLE;
                end
            end
        end
    end

    // Receive FIFO
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  full;
    logic                  pop;
    logic                  wr_en;

    assign full          = (count == FULL_CNT);
    assign m_axis_tvalid = (count != '0);
    assign pop           = m_axis_tvalid && m_axis_tready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_en         = push && (!full || pop);
    assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;
    assign fifo_count    = count;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overrun_error <= 1'b0;
        end else begin
            overrun_error <= push && full && !pop;
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// tb_uart_rx_fifo: serial-frame stimulus for uart_rx_fifo with a
// frame-level reference model of the expected bytes and event pulses.
module tb_uart_rx_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] prescale = 16'd1;
    logic [3:0]  data_bits = 4'd8;
    logic [1:0]  parity_mode = 2'b00;
    logic        two_stop = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [4:0]  fifo_count;
    logic        busy;
    logic        frame_error;
    logic        parity_error;
    logic        overrun_error;
    logic        break_det;

    uart_rx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rxd(rxd),
        .prescale(prescale),
        .data_bits(data_bits),
        .parity_mode(parity_mode),
        .two_stop(two_stop),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .fifo_count(fifo_count),
        .busy(busy),
        .frame_error(frame_error),
        .parity_error(parity_error),
        .overrun_error(overrun_error),
        .break_det(break_det)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int n_frame, n_par, n_ovr, n_brk;
    int e_frame, e_par, e_brk;

    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
        if (frame_error) n_frame++;
        if (parity_error) n_par++;
        if (overrun_error) n_ovr++;
        if (break_det) n_brk++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        got.delete();
        exp_q.delete();
        n_frame = 0; n_par = 0; n_ovr = 0; n_brk = 0;
        e_frame = 0; e_par = 0; e_brk = 0;
    endtask

    function automatic int clamp_nb(input logic [3:0] db);
        if (db < 4'd5) return 5;
        if (db > 4'd8) return 8;
        return int'(db);
    endfunction

    function automatic logic [7:0] mask_of(input int nb);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < nb; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic par_of(input logic [7:0] v,
                                    input logic [1:0] pm);
        return (pm == 2'b10) ? ~(^v) : (^v);
    endfunction

    // Frame-level outcome of one character, from the framing rules.
    function automatic void predict(input logic [3:0] db,
                                    input logic [1:0] pm,
                                    input logic [7:0] data,
                                    input bit bad_par,
                                    input bit bad_stop);
        logic [7:0] v;
        bit pen;
        logic pb;
        v = data & mask_of(clamp_nb(db));
        pen = (pm == 2'b01) || (pm == 2'b10);
        pb = par_of(v, pm) ^ bad_par;
        if (!bad_stop) begin
            if (pen && bad_par) e_par++;
            else exp_q.push_back(v);
        end else if (v == 8'd0 && !(pen && pb)) e_brk++;
        else e_frame++;
    endfunction

    task automatic send_frame(input logic [15:0] ps,
                              input logic [3:0] db,
                              input logic [1:0] pm,
                              input logic ts,
                              input logic [7:0] data,
                              input bit bad_par,
                              input bit bad_stop,
                              input int gap,
                              input bit scramble);
        int nb, bt, ns;
        logic [7:0] v;
        nb = clamp_nb(db);
        bt = (ps == 16'd0) ? 8 : 8 * int'(ps);
        v = data & mask_of(nb);
        prescale = ps; data_bits = db; parity_mode = pm; two_stop = ts;
        rxd = 1'b0;
        tick(bt);
        if (scramble) begin
            prescale = 16'($urandom_range(0, 65535));
            data_bits = 4'($urandom_range(0, 15));
            parity_mode = 2'($urandom_range(0, 3));
            two_stop = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < nb; i++) begin
            rxd = v[i];
            tick(bt);
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            rxd = par_of(v, pm) ^ bad_par;
            tick(bt);
        end
        ns = ts ? 2 : 1;
        for (int s = 0; s < ns; s++) begin
            rxd = (bad_stop && s == ns - 1) ? 1'b0 : 1'b1;
            tick(bt);
        end
        rxd = 1'b1;
        tick(gap * bt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rxd = 1'b1;
        tick(3);
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); else passed++;
        total++; if (m_axis_tdata !== 8'h00) $display("FAIL rst_tdata: got %h want 00", m_axis_tdata); else passed++;
        total++; if (fifo_count !== 5'd0) $display("FAIL rst_count: got %0d want 0", fifo_count); else passed++;
        total++;
        if ({frame_error, parity_error, overrun_error, break_det} !== 4'b0)
            $display("FAIL rst_pulses: got %b want 0000",
                     {frame_error, parity_error, overrun_error, break_det});
        else passed++;
        // Line held low across reset release must be ignored.
        rxd = 1'b0;
        tick(1);
        rst_n = 1'b1;
        clear_mon();
        tick(8 * 15);
        rxd = 1'b1;
        tick(40);
        total++; if (n_brk + n_frame !== 0) $display("FAIL arm_events: got %0d want 0", n_brk + n_frame); else passed++;
        total++; if (got.size() !== 0) $display("FAIL arm_output: got %0d words want 0", got.size()); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL arm_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_walking();
        logic [7:0] b;
        logic [8:0] g;
        clear_mon();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i < 9) b = (i == 0) ? 8'h00 : 8'(1 << (i - 1));
            else b = 8'((1 << (i - 9)) - 1);
            predict(4'd8, 2'b00, b, 1'b0, 1'b0);
            send_frame(16'd1, 4'd8, 2'b00, 1'b0, b, 1'b0, 1'b0, 0, 1'b0);
        end
        tick(30);
        total++; if (got.size() !== 18) $display("FAIL walk_count: got %0d want 18", got.size()); else passed++;
        for (int i = 0; i < 18; i++) begin
            g = (i < got.size()) ? {1'b0, got[i]} : 9'h1FF;
            total++;
            if (g !== {1'b0, exp_q[i]}) $display("FAIL walk_data[%0d]: got %h want %h", i, g, exp_q[i]);
            else passed++;
        end
        total++;
        if (n_frame + n_par + n_ovr + n_brk !== 0)
            $display("FAIL walk_errors: got %0d want 0", n_frame + n_par + n_ovr + n_brk);
        else passed++;
    endtask

    task automatic test_parity();
        clear_mon();
        send_frame(16'd2, 4'd7, 2'b01, 1'b1, 8'h55, 1'b0, 1'b0, 1, 1'b0);
        send_frame(16'd2, 4'd7, 2'b01, 1'b1, 8'h2A, 1'b1, 1'b0, 1, 1'b0);
        tick(20);
        total++; if (got.size() !== 1) $display("FAIL par_count: got %0d want 1", got.size()); else passed++;
        total++;
        if ((got.size() > 0 ? got[0] : 8'hXX) !== 8'h55)
            $display("FAIL par_data: got %h want 55", got.size() > 0 ? got[0] : 8'hXX);
        else passed++;
        total++; if (n_par !== 1) $display("FAIL par_pulse: got %0d want 1", n_par); else passed++;
        total++; if (n_frame !== 0) $display("FAIL par_frame: got %0d want 0", n_frame); else passed++;
    endtask

    task automatic test_overrun();
        logic [7:0] b [17];
        logic [8:0] g;
        clear_mon();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            b[i] = 8'($urandom_range(0, 255));
            send_frame(16'd1, 4'd8, 2'b00, 1'b0, b[i], 1'b0, 1'b0, 0, 1'b0);
        end
        tick(20);
        total++; if (fifo_count !== 5'd16) $display("FAIL ovr_count: got %0d want 16", fifo_count); else passed++;
        total++; if (n_ovr !== 1) $display("FAIL ovr_pulse: got %0d want 1", n_ovr); else passed++;
        total++; if (m_axis_tvalid !== 1'b1) $display("FAIL ovr_tvalid: got %b want 1", m_axis_tvalid); else passed++;
        total++; if (m_axis_tdata !== b[0]) $display("FAIL ovr_head: got %h want %h", m_axis_tdata, b[0]); else passed++;
        tick(10);
        total++; if (m_axis_tdata !== b[0]) $display("FAIL ovr_stable: got %h want %h", m_axis_tdata, b[0]); else passed++;
        m_axis_tready = 1'b1;
        tick(30);
        total++; if (got.size() !== 16) $display("FAIL drain_count: got %0d want 16", got.size()); else passed++;
        for (int i = 0; i < 16; i++) begin
            g = (i < got.size()) ? {1'b0, got[i]} : 9'h1FF;
            total++;
            if (g !== {1'b0, b[i]}) $display("FAIL drain_data[%0d]: got %h want %h", i, g, b[i]);
            else passed++;
        end
        total++; if (fifo_count !== 5'd0) $display("FAIL drain_empty: got %0d want 0", fifo_count); else passed++;
    endtask

    task automatic test_frame_break();
        clear_mon();
        send_frame(16'd1, 4'd8, 2'b00, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 1'b0);
        tick(10);
        total++; if (n_frame !== 1) $display("FAIL frame_pulse: got %0d want 1", n_frame); else passed++;
        total++; if (got.size() !== 0) $display("FAIL frame_output: got %0d want 0", got.size()); else passed++;
        rxd = 1'b0;
        tick(8 * 20);
        total++; if (busy !== 1'b1) $display("FAIL break_busy: got %b want 1", busy); else passed++;
        total++; if (n_brk !== 1) $display("FAIL break_pulse: got %0d want 1", n_brk); else passed++;
        total++; if (n_frame !== 1) $display("FAIL break_noframe: got %0d want 1", n_frame); else passed++;
        rxd = 1'b1;
        tick(8);
        total++; if (busy !== 1'b0) $display("FAIL break_idle: got %b want 0", busy); else passed++;
        send_frame(16'd1, 4'd8, 2'b00, 1'b0, 8'h5A, 1'b0, 1'b0, 1, 1'b0);
        tick(10);
        total++; if (got.size() !== 1) $display("FAIL break_next_cnt: got %0d want 1", got.size()); else passed++;
        total++;
        if ((got.size() > 0 ? got[0] : 8'hXX) !== 8'h5A)
            $display("FAIL break_next: got %h want 5A", got.size() > 0 ? got[0] : 8'hXX);
        else passed++;
    endtask

    task automatic test_glitch();
        clear_mon();
        prescale = 16'd3;
        tick(2);
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(3 * 4 + 4);
        total++; if (busy !== 1'b0) $display("FAIL glitch_busy: got %b want 0", busy); else passed++;
        tick(40);
        total++;
        if (got.size() + n_frame + n_par + n_brk + n_ovr !== 0)
            $display("FAIL glitch_quiet: got %0d events want 0",
                     got.size() + n_frame + n_par + n_brk + n_ovr);
        else passed++;
    endtask

    task automatic test_random();
        logic [15:0] ps;
        logic [3:0] db;
        logic [1:0] pm;
        logic ts;
        logic [7:0] d;
        bit bp, bs;
        logic [8:0] g;
        clear_mon();
        for (int k = 0; k < 40; k++) begin
            ps = 16'($urandom_range(0, 3));
            db = 4'($urandom_range(0, 15));
            pm = 2'($urandom_range(0, 3));
            ts = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 6) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 5) == 0);
            bs = ($urandom_range(0, 5) == 0);
            predict(db, pm, d, bp, bs);
            send_frame(ps, db, pm, ts, d, bp, bs,
                       bs ? 1 : int'($urandom_range(0, 1)), 1'b1);
        end
        tick(50);
        total++; if (got.size() !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size()); else passed++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? {1'b0, got[i]} : 9'h1FF;
            total++;
            if (g !== {1'b0, exp_q[i]}) $display("FAIL rand_data[%0d]: got %h want %h", i, g, exp_q[i]);
            else passed++;
        end
        total++; if (n_par !== e_par) $display("FAIL rand_parity: got %0d want %0d", n_par, e_par); else passed++;
        total++; if (n_frame !== e_frame) $display("FAIL rand_frame: got %0d want %0d", n_frame, e_frame); else passed++;
        total++; if (n_brk !== e_brk) $display("FAIL rand_break: got %0d want %0d", n_brk, e_brk); else passed++;
        total++; if (n_ovr !== 0) $display("FAIL rand_overrun: got %0d want 0", n_ovr); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        clear_mon();
        v = 8'hC3;
        prescale = 16'd1; data_bits = 4'd8; parity_mode = 2'b00; two_stop = 1'b0;
        rxd = 1'b0;
        tick(8);
        for (int i = 0; i < 3; i++) begin
            rxd = v[i];
            tick(8);
        end
        rxd = v[3];
        tick(4);
        rst_n = 1'b0;
        tick(2);
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passed++;
        total++; if (fifo_count !== 5'd0) $display("FAIL midrst_count: got %0d want 0", fifo_count); else passed++;
        rxd = 1'b1;
        rst_n = 1'b1;
        tick(20);
        total++; if (busy !== 1'b0) $display("FAIL midrst_idle: got %b want 0", busy); else passed++;
        total++; if (got.size() !== 0) $display("FAIL midrst_output: got %0d want 0", got.size()); else passed++;
        send_frame(16'd1, 4'd8, 2'b00, 1'b0, 8'h3C, 1'b0, 1'b0, 1, 1'b0);
        tick(10);
        total++; if (got.size() !== 1) $display("FAIL midrst_next_cnt: got %0d want 1", got.size()); else passed++;
        total++;
        if ((got.size() > 0 ? got[0] : 8'hXX) !== 8'h3C)
            $display("FAIL midrst_next: got %h want 3C", got.size() > 0 ? got[0] : 8'hXX);
        else passed++;
    endtask

    initial begin
        tick(1);
        test_reset();
        test_walking();
        test_parity();
        test_overrun();
        test_frame_break();
        test_glitch();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning maximum data bits per character (legal 5..9).
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of 2, >=2).
REQ-003 The module SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 The module SHALL have port rxd, input, 1, meaning the asynchronous serial line, idle high.
REQ-006 The module SHALL have port prescale, input, 16, meaning bit time = prescale*8 clocks; 0 is treated as 1.
REQ-007 The module SHALL have port data_bits, input, 4, meaning character length; values <5 use 5 and values >DATA_WIDTH use DATA_WIDTH.
REQ-008 The module SHALL have port parity_mode, input, 2, meaning 00 none, 01 even, 10 odd, 11 none.
REQ-009 The module SHALL have port two_stop, input, 1, meaning 1 = two stop bits are checked.
REQ-010 The module SHALL have ports m_axis_tdata (DATA_WIDTH, output), m_axis_tvalid (1, output) and m_axis_tready (1, input), meaning the AXI-stream FIFO head.
REQ-011 The module SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1, meaning current FIFO occupancy.
REQ-012 The module SHALL have port busy, output, 1, meaning the receiver FSM is not in IDLE.
REQ-013 The module SHALL have ports frame_error, parity_error, overrun_error and break_det, each an output of width 1, meaning one-cycle error/event pulses.

Function
REQ-014 rxd SHALL pass a 2-flop synchronizer followed by a 3-bit history shift register; each "sample" SHALL be the majority of those 3 bits.
REQ-015 prescale, data_bits, parity_mode and two_stop SHALL be latched when a start is detected, and changes mid-character SHALL have no effect.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP1, STOP2 and WAIT_IDLE.
REQ-017 In IDLE, a synchronized falling edge SHALL enter START and load the timer with prescale*4-1.
REQ-018 At START timer expiry the start bit SHALL be sampled: 0 enters DATA, 1 returns to IDLE with no pulse (glitch reject).
REQ-019 Each later bit SHALL be sampled after prescale*8 clocks, with data LSB first.
REQ-020 Unused upper tdata bits SHALL be 0.
REQ-021 PARITY SHALL be visited only when parity_mode is 01 or 10; a mismatch sets a pending parity flag.
REQ-022 STOP2 SHALL be visited only when two_stop=1.
REQ-023 At the final stop sample, if all stop bits are 1 and parity is ok, the character SHALL be pushed to the FIFO; m_axis_tvalid SHALL rise the next cycle if the FIFO was empty.
REQ-024 If all stop bits are 1 and the pending parity flag is set, parity_error SHALL pulse, nothing SHALL be pushed, and the FSM SHALL go to IDLE.
REQ-025 If any stop sample is 0 and all data bits and the parity bit are 0, break_det SHALL pulse (frame_error SHALL NOT), nothing SHALL be pushed, and the FSM SHALL go to WAIT_IDLE.
REQ-026 If any stop sample is 0 otherwise, frame_error SHALL pulse, nothing SHALL be pushed, and the FSM SHALL go to WAIT_IDLE.
REQ-027 WAIT_IDLE SHALL return to IDLE only after a sample of 1.
REQ-028 On a push with the FIFO full, the word SHALL be dropped and overrun_error SHALL pulse, and FIFO contents SHALL be unchanged.
REQ-029 A simultaneous push and pop with the FIFO full SHALL succeed without overrun, with count unchanged.
REQ-030 The FIFO SHALL pop on tvalid&&tready; tdata SHALL be stable while tvalid=1 and tready=0.
REQ-031 fifo_count SHALL be updated the cycle after a push or pop; simultaneous push+pop SHALL leave it unchanged.
REQ-032 A return to IDLE SHALL permit a new start detection on the very next cycle.

Reset
REQ-033 While rst_n=0, the FSM SHALL be in IDLE, the FIFO SHALL be empty, fifo_count=0, m_axis_tvalid=0, m_axis_tdata=0, busy=0, and all pulses SHALL be 0.
REQ-034 While rst_n=0, the synchronizer and history registers SHALL be preset to 1.
REQ-035 Reset asserted mid-character SHALL discard the partial character.
REQ-036 After rst_n deassertion, rxd SHALL be ignored until 3 consecutive samples of 1.

Verification
REQ-037 With prescale=1, 8N1, tready=1, sending 00,01,02,04,08,10,20,40,80 then 00,01,03,07,0F,1F,3F,7F,FF SHALL produce 18 identical outputs and no error pulses.
REQ-038 With prescale=2, 7 data bits, even parity, 2 stop bits, sending 0x55 then 0x2A with a corrupted parity bit SHALL output 0x55 only and pulse parity_error once.
REQ-039 With tready=0 and FIFO_DEPTH=16, sending 17 bytes SHALL give fifo_count=16 and one overrun_error pulse; draining SHALL return bytes 1..16 in order.
REQ-040 With the stop bit forced 0 on 0xA5, frame_error SHALL pulse; with a low line held for 20 bit times, break_det SHALL pulse once, busy SHALL stay 1 until rxd returns high, and the next byte SHALL be received correctly.
REQ-041 A 2-clock low glitch on idle rxd SHALL cause no output and no pulse, and busy SHALL return to 0 within prescale*4+4 clocks.
REQ-042 Asserting rst_n=0 during bit 3 of a byte SHALL give busy=0, fifo_count=0 and no output, and a subsequent byte 0x3C SHALL be received correctly.
